rob_module: RTL and testbench
=============================

# rob_module

Reorder buffer for the Tomasulo core. Sits directly downstream of the register-file/rename stage:
- accepts each renamed instruction from it and allocates an in-order entry;
- resolves pending operands against completed entries and the FU broadcast, then forwards the instruction to the reservation stations;
- retires entries in program order back to the register file;
- triggers a full flush when a mispredicted branch retires.

## Interface
Parameters:
- ROB_DEPTH, 16: number of entries; power of two.
- ROB_IDX_SIZE, 4: log2(ROB_DEPTH).
- GPR_SIZE, 64: data width.
- GPR_IDX_SIZE, 5: architectural register index width.

Ports:
- in_clk  input  1  single clock; all state changes on its rising edge.
- in_rst  input  1  synchronous reset, active-low: sampled on the in_clk rising edge, 0 = reset.
- in_rf_done  input  1  rename stage presents an instruction this cycle.
- in_rf_src1_valid / in_rf_src2_valid / in_rf_nzcv_valid  input  1 each  operand already architectural.
- in_rf_src1_rob_index / in_rf_src2_rob_index / in_rf_nzcv_rob_index  input  ROB_IDX_SIZE each  producer tag when not valid.
- in_rf_src1_value / in_rf_src2_value  input  GPR_SIZE each  operand value when valid.
- in_rf_nzcv  input  4  flags when valid.
- in_rf_dst  input  GPR_IDX_SIZE  destination register.
- in_rf_set_nzcv, in_rf_uses_nzcv, in_rf_mispredict  input  1 each  instruction attributes.
- in_rf_fu_id / in_rf_fu_op / in_rf_cond_codes  input  fu_t / fu_op_t / cond_t  passthrough to RS.
- in_fu_done  input  1  FU result broadcast valid.
- in_fu_rob_index  input  ROB_IDX_SIZE  tag of the completing entry.
- in_fu_value  input  GPR_SIZE  result.
- in_fu_nzcv  input  4  flags result.
- out_rf_next_rob_index  output  ROB_IDX_SIZE  tag the next allocation receives (equals tail).
- out_d_stall  output  1  ROB full; decode must not issue.
- out_rs_done  output  1  instruction forwarded to RS.
- out_rs_rob_index  output  ROB_IDX_SIZE  its tag.
- out_rs_src1_valid/_rob_index/_value, out_rs_src2_valid/_rob_index/_value, out_rs_nzcv_valid/_rob_index/out_rs_nzcv  output  as inputs  resolved operands.
- out_rs_set_nzcv, out_rs_uses_nzcv, out_rs_fu_id, out_rs_fu_op, out_rs_cond_codes  output  passthrough.
- out_rf_should_commit  output  1  retire pulse.
- out_rf_commit_rob_index, out_rf_reg_index, out_rf_commit_value, out_rf_set_nzcv, out_rf_nzcv  output  retired entry fields.
- out_flush  output  1  mispredicted branch retired.

## Operation
- State:
  - entries[ROB_DEPTH], each holding {busy, done, dst, set_nzcv, mispredict, value, nzcv};
  - head, tail: ROB_IDX_SIZE;
  - count: ROB_IDX_SIZE+1.
- Allocate: on in_rf_done with out_d_stall=0:
  - entries[tail] ← {busy=1, done=0, attributes};
  - tail ← tail+1 mod ROB_DEPTH.
- Allocate while full: in_rf_done with out_d_stall=1 is dropped and does not affect state.
- Operand resolution, applied per src1/src2/nzcv in priority order:
  1. rf valid → pass through.
  2. entries[tag].done → valid=1, value from entry.
  3. in_fu_done and in_fu_rob_index==tag this cycle → valid=1, value from broadcast.
  4. Otherwise valid=0, tag passed through.
- Writeback: on in_fu_done to a busy entry, set value, nzcv and done=1. A writeback to a non-busy entry is ignored.
- Commit: when entries[head] is busy and done:
  - out_rf_* are registered from that entry;
  - busy ← 0; head ← head+1.
  - At most one commit per cycle.
- Flush: a committing entry with mispredict=1 also asserts out_flush. On the same edge, all busy bits are cleared, head=tail=count=0, and a same-cycle allocation is discarded.
- Count bookkeeping: count +1 on allocate, −1 on commit; allocate and commit in the same cycle leave it unchanged.
- out_d_stall = (count==ROB_DEPTH), combinational from registered count.

## Timing
- Reset (in_rst=0 at an edge): all out_* registered outputs 0; head=tail=count=0; all busy=0; out_rf_next_rob_index=0; out_d_stall=0.
- out_rs_*: registered; valid exactly one cycle after the edge that sampled in_rf_done. out_rs_done is a one-cycle pulse per accepted instruction.
- Writeback-to-commit: a result written at edge N makes out_rf_should_commit high during the cycle after edge N+1 (if that entry is head).
- out_rf_should_commit and out_flush are one-cycle pulses.
- Wrap-around: tail=ROB_DEPTH−1 allocation yields next tag 0. Full vs empty is distinguished by count, never by head==tail.
- Writeback to the head entry and allocation in the same cycle are both honoured.

## Structure
- Shared package data_structures.sv: rob_entry_t, nzcv_t, fu_t, fu_op_t, cond_t, ROB_IDX_SIZE, ROB_DEPTH.
- Sub-module rob_operand_resolve: combinational; instantiated three times (src1, src2, nzcv).

## Test plan
- Reset then in_rst=1 → out_rf_next_rob_index=0, out_d_stall=0, all pulses 0.
- Allocate 16 instructions with no writeback:
  - out_d_stall=1 after the 16th;
  - a 17th in_rf_done is ignored, with tail and count unchanged.
- Allocate tag 0 (dst X3) then writeback (tag 0, value 42):
  - next cycle out_rf_should_commit=1, reg_index=3, value=42, commit_rob_index=0.
- Same-cycle forwarding: rename src1 tag 2 (pending) while the FU broadcasts tag 2 = 0x7 → out_rs_src1_valid=1, value=0x7.
- Tag 15 then tag 0 allocation wraps correctly; both commit in order 15, 0.
- Mispredict entry at head completes → out_flush=1 with the commit pulse; next cycle count=0, out_rf_next_rob_index=0.

Source files
------------

// File: rtl/data_structures.sv
// Shared types and sizing for the reorder buffer slice.
// Contents: ROB sizing localparams, the flags type, the functional-unit
// passthrough enums and the packed ROB entry record.
package data_structures;

  localparam int ROB_DEPTH    = 16;
  localparam int ROB_IDX_SIZE = 4;
  localparam int GPR_SIZE     = 64;
  localparam int GPR_IDX_SIZE = 5;

  typedef logic [3:0] nzcv_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MEM = 2'd1,
    FU_BR  = 2'd2,
    FU_MUL = 2'd3
  } fu_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_ORR = 3'd3,
    OP_EOR = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_MOV = 3'd7
  } fu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_t;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [GPR_IDX_SIZE-1:0] dst;
    logic                    set_nzcv;
    logic                    mispredict;
    logic [GPR_SIZE-1:0]     value;
    nzcv_t                   nzcv;
  } rob_entry_t;

endpackage

// File: rtl/rob_operand_resolve.sv
// Combinational operand resolver for one source operand of a renamed
// instruction. Priority: architectural value from rename, then a completed
// ROB entry, then the FU result broadcast this cycle; otherwise the operand
// stays pending and the producer tag is passed on.
// Ports: rf_valid/rf_tag/rf_value (from rename), entry_done/entry_value
// (ROB entry addressed by rf_tag), fu_done/fu_tag/fu_value (broadcast),
// valid/tag/value (resolved operand).
module rob_operand_resolve
  import data_structures::*;
#(
  parameter int W   = 64,
  parameter int IDX = 4
) (
  input  logic           rf_valid,
  input  logic [IDX-1:0] rf_tag,
  input  logic [W-1:0]   rf_value,
  input  logic           entry_done,
  input  logic [W-1:0]   entry_value,
  input  logic           fu_done,
  input  logic [IDX-1:0] fu_tag,
  input  logic [W-1:0]   fu_value,
  output logic           valid,
  output logic [IDX-1:0] tag,
  output logic [W-1:0]   value
);

  // Priority select of the operand source.
  always_comb begin
    valid = 1'b0;
    tag   = rf_tag;
    value = {W{1'b0}};
    if (rf_valid) begin
      valid = 1'b1;
      value = rf_value;
    end else if (entry_done) begin
      valid = 1'b1;
      value = entry_value;
    end else if (fu_done && (fu_tag == rf_tag)) begin
      valid = 1'b1;
      value = fu_value;
    end else begin
      valid = 1'b0;
      value = {W{1'b0}};
    end
  end

endmodule

// File: rtl/rob_module.sv
// Reorder buffer: allocates in-order entries for renamed instructions,
// resolves their operands and forwards them to the reservation stations,
// captures FU writebacks, retires in program order and flushes everything
// when a mispredicted branch retires.
// Ports: in_clk/in_rst (sync active-low), in_rf_* (renamed instruction),
// in_fu_* (result broadcast), out_rf_next_rob_index/out_d_stall (allocation
// status), out_rs_* (instruction to RS), out_rf_* (retire), out_flush.
module rob_module
  import data_structures::*;
#(
  parameter int ROB_DEPTH    = data_structures::ROB_DEPTH,
  parameter int ROB_IDX_SIZE = data_structures::ROB_IDX_SIZE,
  parameter int GPR_SIZE     = data_structures::GPR_SIZE,
  parameter int GPR_IDX_SIZE = data_structures::GPR_IDX_SIZE
) (
  input  logic                    in_clk,
  input  logic                    in_rst,
  input  logic                    in_rf_done,
  input  logic                    in_rf_src1_valid,
  input  logic                    in_rf_src2_valid,
  input  logic                    in_rf_nzcv_valid,
  input  logic [ROB_IDX_SIZE-1:0] in_rf_src1_rob_index,
  input  logic [ROB_IDX_SIZE-1:0] in_rf_src2_rob_index,
  input  logic [ROB_IDX_SIZE-1:0] in_rf_nzcv_rob_index,
  input  logic [GPR_SIZE-1:0]     in_rf_src1_value,
  input  logic [GPR_SIZE-1:0]     in_rf_src2_value,
  input  nzcv_t                   in_rf_nzcv,
  input  logic [GPR_IDX_SIZE-1:0] in_rf_dst,
  input  logic                    in_rf_set_nzcv,
  input  logic                    in_rf_uses_nzcv,
  input  logic                    in_rf_mispredict,
  input  fu_t                     in_rf_fu_id,
  input  fu_op_t                  in_rf_fu_op,
  input  cond_t                   in_rf_cond_codes,
  input  logic                    in_fu_done,
  input  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index,
  input  logic [GPR_SIZE-1:0]     in_fu_value,
  input  nzcv_t                   in_fu_nzcv,
  output logic [ROB_IDX_SIZE-1:0] out_rf_next_rob_index,
  output logic                    out_d_stall,
  output logic                    out_rs_done,
  output logic [ROB_IDX_SIZE-1:0] out_rs_rob_index,
  output logic                    out_rs_src1_valid,
  output logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index,
  output logic [GPR_SIZE-1:0]     out_rs_src1_value,
  output logic                    out_rs_src2_valid,
  output logic [ROB_IDX_SIZE-1:0] out_rs_src2_rob_index,
  output logic [GPR_SIZE-1:0]     out_rs_src2_value,
  output logic                    out_rs_nzcv_valid,
  output logic [ROB_IDX_SIZE-1:0] out_rs_nzcv_rob_index,
  output nzcv_t                   out_rs_nzcv,
  output logic                    out_rs_set_nzcv,
  output logic                    out_rs_uses_nzcv,
  output fu_t                     out_rs_fu_id,
  output fu_op_t                  out_rs_fu_op,
  output cond_t                   out_rs_cond_codes,
  output logic                    out_rf_should_commit,
  output logic [ROB_IDX_SIZE-1:0] out_rf_commit_rob_index,
  output logic [GPR_IDX_SIZE-1:0] out_rf_reg_index,
  output logic [GPR_SIZE-1:0]     out_rf_commit_value,
  output logic                    out_rf_set_nzcv,
  output nzcv_t                   out_rf_nzcv,
  output logic                    out_flush
);

  localparam logic [ROB_IDX_SIZE:0]   FULL_COUNT_C = (ROB_IDX_SIZE+1)'(ROB_DEPTH);
  localparam logic [ROB_IDX_SIZE:0]   CNT_ONE_C    = {{ROB_IDX_SIZE{1'b0}}, 1'b1};
  localparam logic [ROB_IDX_SIZE-1:0] IDX_ONE_C    = {{(ROB_IDX_SIZE-1){1'b0}}, 1'b1};

  rob_entry_t                entries_r [ROB_DEPTH];
  logic [ROB_IDX_SIZE-1:0]   head_r;
  logic [ROB_IDX_SIZE-1:0]   tail_r;
  logic [ROB_IDX_SIZE:0]     count_r;

  rob_entry_t                head_entry_s;
  logic                      commit_s;
  logic                      flush_s;
  logic                      alloc_s;
  logic                      wb_s;

  logic                      src1_valid_s, src2_valid_s, nzcv_valid_s;
  logic [ROB_IDX_SIZE-1:0]   src1_tag_s, src2_tag_s, nzcv_tag_s;
  logic [GPR_SIZE-1:0]       src1_value_s, src2_value_s;
  nzcv_t                     nzcv_value_s;

  assign head_entry_s = entries_r[head_r];
  assign commit_s     = head_entry_s.busy & head_entry_s.done;
  assign flush_s      = commit_s & head_entry_s.mispredict;
  // Full and empty both have head==tail, so fullness comes from the count.
  assign out_d_stall  = (count_r == FULL_COUNT_C);
  // A retiring mispredict discards whatever rename offers on the same edge.
  assign alloc_s      = in_rf_done & ~out_d_stall & ~flush_s;
  assign wb_s         = in_fu_done & entries_r[in_fu_rob_index].busy;
  assign out_rf_next_rob_index = tail_r;

  rob_operand_resolve #(.W(GPR_SIZE), .IDX(ROB_IDX_SIZE)) u_res_src1 (
    .rf_valid(in_rf_src1_valid), .rf_tag(in_rf_src1_rob_index), .rf_value(in_rf_src1_value),
    .entry_done(entries_r[in_rf_src1_rob_index].done),
    .entry_value(entries_r[in_rf_src1_rob_index].value),
    .fu_done(in_fu_done), .fu_tag(in_fu_rob_index), .fu_value(in_fu_value),
    .valid(src1_valid_s), .tag(src1_tag_s), .value(src1_value_s)
  );

  rob_operand_resolve #(.W(GPR_SIZE), .IDX(ROB_IDX_SIZE)) u_res_src2 (
    .rf_valid(in_rf_src2_valid), .rf_tag(in_rf_src2_rob_index), .rf_value(in_rf_src2_value),
    .entry_done(entries_r[in_rf_src2_rob_index].done),
    .entry_value(entries_r[in_rf_src2_rob_index].value),
    .fu_done(in_fu_done), .fu_tag(in_fu_rob_index), .fu_value(in_fu_value),
    .valid(src2_valid_s), .tag(src2_tag_s), .value(src2_value_s)
  );

  rob_operand_resolve #(.W(4), .IDX(ROB_IDX_SIZE)) u_res_nzcv (
    .rf_valid(in_rf_nzcv_valid), .rf_tag(in_rf_nzcv_rob_index), .rf_value(in_rf_nzcv),
    .entry_done(entries_r[in_rf_nzcv_rob_index].done),
    .entry_value(entries_r[in_rf_nzcv_rob_index].nzcv),
    .fu_done(in_fu_done), .fu_tag(in_fu_rob_index), .fu_value(in_fu_nzcv),
    .valid(nzcv_valid_s), .tag(nzcv_tag_s), .value(nzcv_value_s)
  );

  // Entry array, pointers, count and all registered outputs.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_r[i] <= {$bits(rob_entry_t){1'b0}};
      end
      head_r                  <= {ROB_IDX_SIZE{1'b0}};
      tail_r                  <= {ROB_IDX_SIZE{1'b0}};
      count_r                 <= {(ROB_IDX_SIZE+1){1'b0}};
      out_rs_done             <= 1'b0;
      out_rs_rob_index        <= {ROB_IDX_SIZE{1'b0}};
      out_rs_src1_valid       <= 1'b0;
      out_rs_src1_rob_index   <= {ROB_IDX_SIZE{1'b0}};
      out_rs_src1_value       <= {GPR_SIZE{1'b0}};
      out_rs_src2_valid       <= 1'b0;
      out_rs_src2_rob_index   <= {ROB_IDX_SIZE{1'b0}};
      out_rs_src2_value       <= {GPR_SIZE{1'b0}};
      out_rs_nzcv_valid       <= 1'b0;
      out_rs_nzcv_rob_index   <= {ROB_IDX_SIZE{1'b0}};
      out_rs_nzcv             <= 4'd0;
      out_rs_set_nzcv         <= 1'b0;
      out_rs_uses_nzcv        <= 1'b0;
      out_rs_fu_id            <= FU_ALU;
      out_rs_fu_op            <= OP_ADD;
      out_rs_cond_codes       <= COND_EQ;
      out_rf_should_commit    <= 1'b0;
      out_rf_commit_rob_index <= {ROB_IDX_SIZE{1'b0}};
      out_rf_reg_index        <= {GPR_IDX_SIZE{1'b0}};
      out_rf_commit_value     <= {GPR_SIZE{1'b0}};
      out_rf_set_nzcv         <= 1'b0;
      out_rf_nzcv             <= 4'd0;
      out_flush               <= 1'b0;
    end else begin
      out_rs_done <= alloc_s;
      if (alloc_s) begin
        out_rs_rob_index      <= tail_r;
        out_rs_src1_valid     <= src1_valid_s;
        out_rs_src1_rob_index <= src1_tag_s;
        out_rs_src1_value     <= src1_value_s;
        out_rs_src2_valid     <= src2_valid_s;
        out_rs_src2_rob_index <= src2_tag_s;
        out_rs_src2_value     <= src2_value_s;
        out_rs_nzcv_valid     <= nzcv_valid_s;
        out_rs_nzcv_rob_index <= nzcv_tag_s;
        out_rs_nzcv           <= nzcv_value_s;
        out_rs_set_nzcv       <= in_rf_set_nzcv;
        out_rs_uses_nzcv      <= in_rf_uses_nzcv;
        out_rs_fu_id          <= in_rf_fu_id;
        out_rs_fu_op          <= in_rf_fu_op;
        out_rs_cond_codes     <= in_rf_cond_codes;
      end

      out_rf_should_commit <= commit_s;
      out_flush            <= flush_s;
      if (commit_s) begin
        out_rf_commit_rob_index <= head_r;
        out_rf_reg_index        <= head_entry_s.dst;
        out_rf_commit_value     <= head_entry_s.value;
        out_rf_set_nzcv         <= head_entry_s.set_nzcv;
        out_rf_nzcv             <= head_entry_s.nzcv;
      end

      if (wb_s) begin
        entries_r[in_fu_rob_index].value <= in_fu_value;
        entries_r[in_fu_rob_index].nzcv  <= in_fu_nzcv;
        entries_r[in_fu_rob_index].done  <= 1'b1;
      end

      if (flush_s) begin
        for (int i = 0; i < ROB_DEPTH; i++) begin
          entries_r[i].busy <= 1'b0;
        end
        head_r  <= {ROB_IDX_SIZE{1'b0}};
        tail_r  <= {ROB_IDX_SIZE{1'b0}};
        count_r <= {(ROB_IDX_SIZE+1){1'b0}};
      end else begin
        if (commit_s) begin
          entries_r[head_r].busy <= 1'b0;
          head_r                 <= head_r + IDX_ONE_C;
        end
        if (alloc_s) begin
          entries_r[tail_r] <= '{busy: 1'b1, done: 1'b0, dst: in_rf_dst,
                                 set_nzcv: in_rf_set_nzcv, mispredict: in_rf_mispredict,
                                 value: {GPR_SIZE{1'b0}}, nzcv: 4'd0};
          tail_r            <= tail_r + IDX_ONE_C;
        end
        case ({alloc_s, commit_s})
          2'b10:   count_r <= count_r + CNT_ONE_C;
          2'b01:   count_r <= count_r - CNT_ONE_C;
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_module.sv
// Self-checking bench for rob_module: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model of the
// reorder buffer kept in the bench.
module tb_rob_module;
  import data_structures::*;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic        in_rf_done, in_rf_src1_valid, in_rf_src2_valid, in_rf_nzcv_valid;
  logic [3:0]  in_rf_src1_rob_index, in_rf_src2_rob_index, in_rf_nzcv_rob_index;
  logic [63:0] in_rf_src1_value, in_rf_src2_value;
  nzcv_t       in_rf_nzcv;
  logic [4:0]  in_rf_dst;
  logic        in_rf_set_nzcv, in_rf_uses_nzcv, in_rf_mispredict;
  fu_t         in_rf_fu_id;
  fu_op_t      in_rf_fu_op;
  cond_t       in_rf_cond_codes;
  logic        in_fu_done;
  logic [3:0]  in_fu_rob_index;
  logic [63:0] in_fu_value;
  nzcv_t       in_fu_nzcv;

  logic [3:0]  out_rf_next_rob_index, out_rs_rob_index;
  logic        out_d_stall, out_rs_done;
  logic        out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid;
  logic [3:0]  out_rs_src1_rob_index, out_rs_src2_rob_index, out_rs_nzcv_rob_index;
  logic [63:0] out_rs_src1_value, out_rs_src2_value;
  nzcv_t       out_rs_nzcv;
  logic        out_rs_set_nzcv, out_rs_uses_nzcv;
  fu_t         out_rs_fu_id;
  fu_op_t      out_rs_fu_op;
  cond_t       out_rs_cond_codes;
  logic        out_rf_should_commit;
  logic [3:0]  out_rf_commit_rob_index;
  logic [4:0]  out_rf_reg_index;
  logic [63:0] out_rf_commit_value;
  logic        out_rf_set_nzcv;
  nzcv_t       out_rf_nzcv;
  logic        out_flush;

  rob_module dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_rf_done(in_rf_done),
    .in_rf_src1_valid(in_rf_src1_valid), .in_rf_src2_valid(in_rf_src2_valid),
    .in_rf_nzcv_valid(in_rf_nzcv_valid),
    .in_rf_src1_rob_index(in_rf_src1_rob_index), .in_rf_src2_rob_index(in_rf_src2_rob_index),
    .in_rf_nzcv_rob_index(in_rf_nzcv_rob_index),
    .in_rf_src1_value(in_rf_src1_value), .in_rf_src2_value(in_rf_src2_value),
    .in_rf_nzcv(in_rf_nzcv), .in_rf_dst(in_rf_dst),
    .in_rf_set_nzcv(in_rf_set_nzcv), .in_rf_uses_nzcv(in_rf_uses_nzcv),
    .in_rf_mispredict(in_rf_mispredict),
    .in_rf_fu_id(in_rf_fu_id), .in_rf_fu_op(in_rf_fu_op), .in_rf_cond_codes(in_rf_cond_codes),
    .in_fu_done(in_fu_done), .in_fu_rob_index(in_fu_rob_index),
    .in_fu_value(in_fu_value), .in_fu_nzcv(in_fu_nzcv),
    .out_rf_next_rob_index(out_rf_next_rob_index), .out_d_stall(out_d_stall),
    .out_rs_done(out_rs_done), .out_rs_rob_index(out_rs_rob_index),
    .out_rs_src1_valid(out_rs_src1_valid), .out_rs_src1_rob_index(out_rs_src1_rob_index),
    .out_rs_src1_value(out_rs_src1_value),
    .out_rs_src2_valid(out_rs_src2_valid), .out_rs_src2_rob_index(out_rs_src2_rob_index),
    .out_rs_src2_value(out_rs_src2_value),
    .out_rs_nzcv_valid(out_rs_nzcv_valid), .out_rs_nzcv_rob_index(out_rs_nzcv_rob_index),
    .out_rs_nzcv(out_rs_nzcv),
    .out_rs_set_nzcv(out_rs_set_nzcv), .out_rs_uses_nzcv(out_rs_uses_nzcv),
    .out_rs_fu_id(out_rs_fu_id), .out_rs_fu_op(out_rs_fu_op),
    .out_rs_cond_codes(out_rs_cond_codes),
    .out_rf_should_commit(out_rf_should_commit),
    .out_rf_commit_rob_index(out_rf_commit_rob_index), .out_rf_reg_index(out_rf_reg_index),
    .out_rf_commit_value(out_rf_commit_value), .out_rf_set_nzcv(out_rf_set_nzcv),
    .out_rf_nzcv(out_rf_nzcv), .out_flush(out_flush)
  );

  always #5 in_clk = ~in_clk;

  int ncmp = 0;
  int nfail = 0;

  // Model: program-order queue of in-flight tags plus per-tag records.
  int          q[$];
  int          m_tail;
  bit          m_busy [16];
  bit          m_done [16];
  bit          m_misp [16];
  bit          m_setn [16];
  logic [4:0]  m_dst  [16];
  logic [63:0] m_val  [16];
  logic [3:0]  m_nzcv [16];

  // Expected registered outputs after the coming edge.
  bit          e_rs_done, e_s1v, e_s2v, e_nv, e_setn, e_uses, e_cm, e_cm_setn, e_flush;
  logic [3:0]  e_rs_idx, e_s1t, e_s2t, e_nt, e_cm_idx, e_cm_nzcv;
  logic [63:0] e_s1val, e_s2val, e_nval, e_cm_val;
  logic [4:0]  e_cm_reg;
  fu_t         e_fu_id;
  fu_op_t      e_fu_op;
  cond_t       e_cond;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tail = 0;
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endtask

  task automatic resolve(input logic rv, input logic [3:0] tag, input logic [63:0] rval,
                         input bit is_n, output bit ov, output logic [63:0] oval);
    ov = 1'b1;
    if (rv) oval = rval;
    else if (m_done[tag]) oval = is_n ? {60'd0, m_nzcv[tag]} : m_val[tag];
    else if (in_fu_done && in_fu_rob_index == tag) oval = is_n ? {60'd0, in_fu_nzcv} : in_fu_value;
    else begin
      ov = 1'b0;
      oval = 64'd0;
    end
  endtask

  // One clock: predict from pre-edge model state and current inputs,
  // advance the model, then compare the DUT after the edge.
  task automatic step();
    bit stall, commit, flush, alloc;
    int h, w;
    chk("d_stall", {63'd0, out_d_stall}, {63'd0, (q.size() == 16)});
    chk("next_rob_index", {60'd0, out_rf_next_rob_index}, 64'(m_tail));
    stall  = (q.size() == 16);
    commit = (q.size() > 0) && m_done[q[0]];
    flush  = commit && m_misp[q[0]];
    alloc  = in_rf_done && !stall && !flush;

    e_rs_done = alloc;
    if (alloc) begin
      e_rs_idx = 4'(m_tail);
      e_s1t = in_rf_src1_rob_index;
      e_s2t = in_rf_src2_rob_index;
      e_nt  = in_rf_nzcv_rob_index;
      resolve(in_rf_src1_valid, in_rf_src1_rob_index, in_rf_src1_value, 1'b0, e_s1v, e_s1val);
      resolve(in_rf_src2_valid, in_rf_src2_rob_index, in_rf_src2_value, 1'b0, e_s2v, e_s2val);
      resolve(in_rf_nzcv_valid, in_rf_nzcv_rob_index, {60'd0, in_rf_nzcv}, 1'b1, e_nv, e_nval);
      e_setn = in_rf_set_nzcv;
      e_uses = in_rf_uses_nzcv;
      e_fu_id = in_rf_fu_id;
      e_fu_op = in_rf_fu_op;
      e_cond = in_rf_cond_codes;
    end
    e_cm = commit;
    e_flush = flush;
    if (commit) begin
      h = q[0];
      e_cm_idx = 4'(h);
      e_cm_reg = m_dst[h];
      e_cm_val = m_val[h];
      e_cm_setn = m_setn[h];
      e_cm_nzcv = m_nzcv[h];
    end

    w = int'(in_fu_rob_index);
    if (in_fu_done && m_busy[w]) begin
      m_done[w] = 1'b1;
      m_val[w]  = in_fu_value;
      m_nzcv[w] = in_fu_nzcv;
    end
    if (commit) begin
      m_busy[q[0]] = 1'b0;
      void'(q.pop_front());
    end
    if (flush) begin
      foreach (q[k]) m_busy[q[k]] = 1'b0;
      q.delete();
      m_tail = 0;
    end
    if (alloc) begin
      m_busy[m_tail] = 1'b1;
      m_done[m_tail] = 1'b0;
      m_misp[m_tail] = in_rf_mispredict;
      m_setn[m_tail] = in_rf_set_nzcv;
      m_dst[m_tail]  = in_rf_dst;
      q.push_back(m_tail);
      m_tail = (m_tail + 1) % 16;
    end

    @(posedge in_clk);
    @(negedge in_clk);
    chk("rs_done", {63'd0, out_rs_done}, {63'd0, e_rs_done});
    if (e_rs_done) begin
      chk("rs_rob_index", {60'd0, out_rs_rob_index}, {60'd0, e_rs_idx});
      chk("rs_src1_valid", {63'd0, out_rs_src1_valid}, {63'd0, e_s1v});
      chk("rs_src1_tag", {60'd0, out_rs_src1_rob_index}, {60'd0, e_s1t});
      if (e_s1v) chk("rs_src1_value", out_rs_src1_value, e_s1val);
      chk("rs_src2_valid", {63'd0, out_rs_src2_valid}, {63'd0, e_s2v});
      chk("rs_src2_tag", {60'd0, out_rs_src2_rob_index}, {60'd0, e_s2t});
      if (e_s2v) chk("rs_src2_value", out_rs_src2_value, e_s2val);
      chk("rs_nzcv_valid", {63'd0, out_rs_nzcv_valid}, {63'd0, e_nv});
      chk("rs_nzcv_tag", {60'd0, out_rs_nzcv_rob_index}, {60'd0, e_nt});
      if (e_nv) chk("rs_nzcv", {60'd0, out_rs_nzcv}, e_nval);
      chk("rs_attrs", {57'd0, out_rs_set_nzcv, out_rs_uses_nzcv, out_rs_fu_id, out_rs_fu_op},
          {57'd0, e_setn, e_uses, e_fu_id, e_fu_op});
      chk("rs_cond", {60'd0, out_rs_cond_codes}, {60'd0, e_cond});
    end
    chk("should_commit", {63'd0, out_rf_should_commit}, {63'd0, e_cm});
    chk("flush", {63'd0, out_flush}, {63'd0, e_flush});
    if (e_cm) begin
      chk("commit_rob_index", {60'd0, out_rf_commit_rob_index}, {60'd0, e_cm_idx});
      chk("commit_reg", {59'd0, out_rf_reg_index}, {59'd0, e_cm_reg});
      chk("commit_value", out_rf_commit_value, e_cm_val);
      chk("commit_nzcv", {59'd0, out_rf_set_nzcv, out_rf_nzcv}, {59'd0, e_cm_setn, e_cm_nzcv});
    end
  endtask

  task automatic idle();
    in_rf_done = 1'b0;
    in_rf_mispredict = 1'b0;
    in_fu_done = 1'b0;
  endtask

  task automatic set_alloc(input logic [4:0] dst, input bit misp);
    in_rf_done = 1'b1;
    in_rf_dst = dst;
    in_rf_mispredict = misp;
    in_rf_src1_valid = 1'b1;
    in_rf_src2_valid = 1'b1;
    in_rf_nzcv_valid = 1'b1;
    in_rf_src1_rob_index = 4'($urandom);
    in_rf_src2_rob_index = 4'($urandom);
    in_rf_nzcv_rob_index = 4'($urandom);
    in_rf_src1_value = {$urandom, $urandom};
    in_rf_src2_value = {$urandom, $urandom};
    in_rf_nzcv = 4'($urandom);
    in_rf_set_nzcv = 1'($urandom);
    in_rf_uses_nzcv = 1'($urandom);
    in_rf_fu_id = fu_t'(2'($urandom));
    in_rf_fu_op = fu_op_t'(3'($urandom));
    in_rf_cond_codes = cond_t'(4'($urandom));
  endtask

  task automatic set_wb(input logic [3:0] tag, input logic [63:0] val);
    in_fu_done = 1'b1;
    in_fu_rob_index = tag;
    in_fu_value = val;
    in_fu_nzcv = 4'($urandom);
  endtask

  // Pending-or-ready operand for randomized renames.
  task automatic gen_op(output logic v, output logic [3:0] t, output logic [63:0] val);
    val = {$urandom, $urandom};
    if (q.size() == 0 || $urandom_range(0, 2) == 0) begin
      v = 1'b1;
      t = 4'($urandom);
    end else begin
      v = 1'b0;
      if (in_fu_done && m_busy[in_fu_rob_index] && $urandom_range(0, 2) == 0) t = in_fu_rob_index;
      else t = 4'(q[$urandom_range(0, q.size() - 1)]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin
      idle();
      foreach (q[k]) begin
        if (!m_done[q[k]] && !in_fu_done) set_wb(4'(q[k]), {$urandom, $urandom});
      end
      step();
      n++;
    end
    idle();
    if (q.size() > 0) begin
      ncmp++;
      nfail++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;
    logic [3:0] t;
    logic [63:0] val;
    idle();
    set_alloc(5'd0, 1'b0);
    in_rf_done = 1'b0;
    in_fu_rob_index = 4'd0;
    in_fu_value = 64'd0;
    in_fu_nzcv = 4'd0;
    in_rst = 1'b0;
    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    model_reset();
    chk("rst_rs_done", {63'd0, out_rs_done}, 64'd0);
    chk("rst_should_commit", {63'd0, out_rf_should_commit}, 64'd0);
    chk("rst_flush", {63'd0, out_flush}, 64'd0);
    chk("rst_commit_value", out_rf_commit_value, 64'd0);
    chk("rst_stall", {63'd0, out_d_stall}, 64'd0);
    chk("rst_next_idx", {60'd0, out_rf_next_rob_index}, 64'd0);
    in_rst = 1'b1;

    // Fill all 16 entries, then try a 17th.
    for (int i = 0; i < 16; i++) begin
      set_alloc(5'(i), 1'b0);
      step();
    end
    chk("full_stall", {63'd0, out_d_stall}, 64'd1);
    chk("full_next_idx", {60'd0, out_rf_next_rob_index}, 64'd0);
    set_alloc(5'd9, 1'b0);
    step();
    chk("drop_rs_done", {63'd0, out_rs_done}, 64'd0);
    chk("drop_stall", {63'd0, out_d_stall}, 64'd1);
    chk("drop_next_idx", {60'd0, out_rf_next_rob_index}, 64'd0);
    drain();

    // Tag 0 to X3, writeback 42, commit.
    set_alloc(5'd3, 1'b0);
    step();
    chk("x3_rs_idx", {60'd0, out_rs_rob_index}, 64'd0);
    idle();
    set_wb(4'd0, 64'd42);
    step();
    idle();
    step();
    chk("x3_commit", {63'd0, out_rf_should_commit}, 64'd1);
    chk("x3_reg", {59'd0, out_rf_reg_index}, 64'd3);
    chk("x3_value", out_rf_commit_value, 64'd42);
    chk("x3_idx", {60'd0, out_rf_commit_rob_index}, 64'd0);

    // Same-cycle forwarding from the FU broadcast (tags 1, 2 pending).
    set_alloc(5'd1, 1'b0); step();
    set_alloc(5'd2, 1'b0); step();
    set_alloc(5'd4, 1'b0);
    in_rf_src1_valid = 1'b0;
    in_rf_src1_rob_index = 4'd2;
    set_wb(4'd2, 64'h7);
    step();
    chk("fwd_rs_idx", {60'd0, out_rs_rob_index}, 64'd3);
    chk("fwd_valid", {63'd0, out_rs_src1_valid}, 64'd1);
    chk("fwd_value", out_rs_src1_value, 64'h7);
    drain();

    // Move tail to 15, then wrap to 0.
    for (int i = 0; i < 11; i++) begin
      set_alloc(5'(i), 1'b0);
      step();
    end
    drain();
    set_alloc(5'd10, 1'b0); step();
    chk("wrap_idx15", {60'd0, out_rs_rob_index}, 64'd15);
    set_alloc(5'd11, 1'b0); step();
    chk("wrap_idx0", {60'd0, out_rs_rob_index}, 64'd0);
    chk("wrap_next", {60'd0, out_rf_next_rob_index}, 64'd1);
    idle(); set_wb(4'd0, 64'h100); step();
    idle(); set_wb(4'd15, 64'h1500); step();
    idle(); step();
    chk("wrap_commit15", {60'd0, out_rf_commit_rob_index}, 64'd15);
    chk("wrap_value15", out_rf_commit_value, 64'h1500);
    step();
    chk("wrap_commit0", {60'd0, out_rf_commit_rob_index}, 64'd0);
    chk("wrap_value0", out_rf_commit_value, 64'h100);

    // Mispredict at head: flush, same-cycle allocation discarded.
    set_alloc(5'd7, 1'b1); step();
    set_alloc(5'd8, 1'b0); step();
    idle(); set_wb(4'd1, 64'h55); step();
    set_alloc(5'd9, 1'b0); step();
    chk("mp_flush", {63'd0, out_flush}, 64'd1);
    chk("mp_commit", {63'd0, out_rf_should_commit}, 64'd1);
    chk("mp_rs_done", {63'd0, out_rs_done}, 64'd0);
    chk("mp_next_idx", {60'd0, out_rf_next_rob_index}, 64'd0);
    chk("mp_stall", {63'd0, out_d_stall}, 64'd0);
    idle(); step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        if (q.size() > 0 && $urandom_range(0, 4) != 0)
          set_wb(4'(q[$urandom_range(0, q.size() - 1)]), {$urandom, $urandom});
        else
          set_wb(4'($urandom), {$urandom, $urandom});
      end
      set_alloc(5'($urandom), ($urandom_range(0, 15) == 0));
      in_rf_done = ($urandom_range(0, 9) < 7);
      gen_op(v, t, val);
      in_rf_src1_valid = v; in_rf_src1_rob_index = t; in_rf_src1_value = val;
      gen_op(v, t, val);
      in_rf_src2_valid = v; in_rf_src2_rob_index = t; in_rf_src2_value = val;
      gen_op(v, t, val);
      in_rf_nzcv_valid = v; in_rf_nzcv_rob_index = t; in_rf_nzcv = val[3:0];
      step();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
